// File: rtl/freq_counter.sv
// Gated event counter: counts synchronized rising edges of sig_in over
// back-to-back windows of GATE_CYCLES clocks and strobes each result out.
`timescale 1ns/1ps
module freq_counter #(
  parameter int INPUT_WIDTH = 32,
  parameter int GATE_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   sig_in,
  output logic [INPUT_WIDTH-1:0] num_out,
  output logic                   num_valid,
  output logic                   overflow,
  output logic                   busy
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0]          GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [INPUT_WIDTH-1:0] CNT_MAX   = '1;

  localparam logic IDLE = 1'b0;
  localparam logic GATE = 1'b1;

  logic                   s1, s2, p;
  logic                   sig_edge;
  logic                   state;
  logic [GW-1:0]          gate_cnt;
  logic [INPUT_WIDTH-1:0] edge_cnt;
  logic                   sat;
  logic                   cnt_full;
  logic [INPUT_WIDTH-1:0] cnt_next;
  logic                   sat_next;

  // NOTE: every register below uses non-blocking assignments so that all
  // flops sample the pre-edge values and the synchronizer chain shifts by
  // exactly one stage per clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      p  <= s2;
    end
  end

  assign sig_edge = s2 & ~p;
  assign cnt_full = (edge_cnt == CNT_MAX);
  assign cnt_next = (sig_edge && !cnt_full) ? edge_cnt + INPUT_WIDTH'(1) : edge_cnt;
  assign sat_next = sat | (sig_edge & cnt_full);
  assign busy     = (state == GATE);

  // The final window cycle takes priority over an abort: its edge is folded
  // into the result and the counters restart with no gap cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      sat       <= 1'b0;
      num_out   <= '0;
      overflow  <= 1'b0;
      num_valid <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          if (enable) state <= GATE;
        end
        GATE: begin
          if (gate_cnt == GATE_LAST) begin
            num_out   <= cnt_next;
            overflow  <= sat_next;
            num_valid <= 1'b1;
            gate_cnt  <= '0;
            edge_cnt  <= '0;
            sat       <= 1'b0;
            if (!enable) state <= IDLE;
          end else if (!enable) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GW'(1);
            edge_cnt <= cnt_next;
            sat      <= sat_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_counter.sv
// Bench for freq_counter: two widths (8 and 5) share one stimulus stream and are
// compared every cycle against a window/edge-list model of the counter.
`timescale 1ns/1ps
module tb_freq_counter;

  localparam int G = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       sig_in = 1'b0;
  logic [7:0] num8;
  logic       v8, o8, b8;
  logic [4:0] num5;
  logic       v5, o5, b5;

  always #5 clk = ~clk;

  freq_counter #(.INPUT_WIDTH(8), .GATE_CYCLES(G)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .num_out(num8), .num_valid(v8), .overflow(o8), .busy(b8));

  freq_counter #(.INPUT_WIDTH(5), .GATE_CYCLES(G)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .num_out(num5), .num_valid(v5), .overflow(o5), .busy(b5));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a rise of sig_in seen at clock k is counted at clock k+2;
  // a window opened at clock S owns the counts landing on clocks S+1..S+G.
  bit last_sig, d1, d2;
  bit m_busy, m_valid;
  int m_pos, m_cnt;
  int exp_num8, exp_num5;
  bit exp_ovf8, exp_ovf5;

  task automatic model_reset();
    last_sig = 0; d1 = 0; d2 = 0;
    m_busy = 0; m_valid = 0; m_pos = 0; m_cnt = 0;
    exp_num8 = 0; exp_num5 = 0; exp_ovf8 = 0; exp_ovf5 = 0;
  endtask

  task automatic model_step();
    bit rise, counted;
    rise     = sig_in && !last_sig;
    last_sig = sig_in;
    counted  = d2;
    d2       = d1;
    d1       = rise;
    m_valid  = 0;
    if (!m_busy) begin
      if (enable) begin
        m_busy = 1; m_pos = 0; m_cnt = 0;
      end
    end else begin
      m_cnt += int'(counted);
      m_pos++;
      if (m_pos == G) begin
        exp_num8 = (m_cnt > 255) ? 255 : m_cnt;
        exp_ovf8 = (m_cnt > 255);
        exp_num5 = (m_cnt > 31) ? 31 : m_cnt;
        exp_ovf5 = (m_cnt > 31);
        m_valid  = 1;
        m_pos = 0; m_cnt = 0;
        m_busy = enable;
      end else if (!enable) begin
        m_busy = 0; m_pos = 0; m_cnt = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  int strobes = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("num8",   num8, exp_num8);
      check("ovf8",   o8,   exp_ovf8);
      check("valid8", v8,   m_valid);
      check("busy8",  b8,   m_busy);
      check("num5",   num5, exp_num5);
      check("ovf5",   o5,   exp_ovf5);
      check("valid5", v5,   m_valid);
      check("busy5",  b5,   m_busy);
      if (v8) strobes++;
    end
  end

  // sig_period: >0 square wave, 0 random bits, -1 held low, -2 driven by hand
  int sig_period = 0;
  int phase = 0;

  task automatic set_period(input int per);
    sig_period = per;
    phase = 0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (sig_period == 0) sig_in = 1'($urandom % 2);
      else if (sig_period == -1) sig_in = 1'b0;
      else if (sig_period > 0) begin
        sig_in = (phase < sig_period / 2);
        phase = (phase + 1) % sig_period;
      end
    end
  endtask

  task automatic wait_pos(input int pos, input int limit);
    int n = 0;
    while (!(m_busy && m_pos == pos) && n < limit) begin
      run(1);
      n++;
    end
    check("wait_bound", 32'(m_busy && m_pos == pos), 1);
  endtask

  int s0;

  initial begin
    // Reset held with sig_in toggling
    set_period(0);
    run(10);
    check("rst_num8", num8, 0);
    check("rst_valid8", v8, 0);
    check("rst_busy8", b8, 0);
    check("rst_ovf5", o5, 0);
    reset_n = 1'b1;
    run(20);
    check("idle_busy", b8, 0);
    check("idle_num", num8, 0);

    // Steady count, period 10
    set_period(10);
    enable = 1'b1;
    s0 = strobes;
    run(3 * G + 5);
    check("steady_strobes", strobes - s0, 3);
    check("steady_num8", num8, 10);
    check("steady_busy", b8, 1);

    // Saturation then recovery
    set_period(2);
    run(3 * G);
    check("sat_num5", num5, 31);
    check("sat_ovf5", o5, 1);
    check("sat_num8", num8, 50);
    check("sat_ovf8", o8, 0);
    set_period(10);
    run(3 * G);
    check("rec_num5", num5, 10);
    check("rec_ovf5", o5, 0);

    // Abort 50 cycles into a window
    wait_pos(50, 3 * G);
    s0 = strobes;
    enable = 1'b0;
    run(1);
    check("abort_busy", b8, 0);
    run(20);
    check("abort_num8", num8, 10);
    check("abort_strobes", strobes - s0, 0);
    enable = 1'b1;
    run(G);
    check("reen_no_valid", v8, 0);
    run(1);
    check("reen_valid", v8, 1);
    check("reen_num8", num8, 10);

    // Boundary: edge lands in the last cycle of a window
    set_period(-1);
    run(G + 5);
    wait_pos(G - 3, 2 * G);
    set_period(-2);
    sig_in = 1'b1;
    run(2);
    sig_in = 1'b0;
    run(1);
    check("bound_valid", v8, 1);
    check("bound_num8", num8, 1);
    sig_in = 1'b1;
    run(2);
    sig_in = 1'b0;
    s0 = strobes;
    run(G);
    check("bound_next_num8", num8, 1);
    check("bound_next_strobes", strobes - s0, 1);

    // Async reset 40 cycles into a window
    set_period(10);
    wait_pos(40, 2 * G);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    check("arst_num8", num8, 0);
    check("arst_valid8", v8, 0);
    check("arst_busy8", b8, 0);
    check("arst_ovf5", o5, 0);
    #2;
    reset_n = 1'b1;
    s0 = strobes;
    run(10);
    enable = 1'b1;
    run(G);
    check("arst_no_strobe", strobes - s0, 0);
    run(1);
    check("arst_fresh_valid", v8, 1);

    // Random sig_in with occasional enable drops
    set_period(0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      run(1);
    end
    enable = 1'b1;
    run(2 * G);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
